// File: rtl/commit_trace_buffer_pkg.sv
// commit_trace_buffer_pkg: shared trace-buffer types, FSM encoding and default sizing
package commit_trace_buffer_pkg;
  localparam int TRACE_DEPTH = 64;
  localparam int WATCHDOG_CYCLES = 1024;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FROZEN  = 2'd2,
    DRAIN   = 2'd3
  } TraceState;
  typedef logic [$clog2(TRACE_DEPTH)-1:0] TraceIndexPath;
  typedef logic [$clog2(TRACE_DEPTH):0] TraceCountPath;
endpackage

// File: rtl/commit_lane_compactor.sv
// commit_lane_compactor: packs valid commit lanes in lane order and counts them
module commit_lane_compactor #(
  parameter int COMMIT_WIDTH = 2,
  parameter int PC_WIDTH = 32,
  parameter int COUNT_WIDTH = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic [COMMIT_WIDTH-1:0]          cmValid,
  input  logic [COMMIT_WIDTH*PC_WIDTH-1:0] cmPC,
  output logic [COMMIT_WIDTH*PC_WIDTH-1:0] lanePcs,
  output logic [COUNT_WIDTH-1:0]           laneCount
);
  // slot k of lanePcs holds the k-th valid lane, so lane 0 is always the oldest write
  always_comb begin
    int pos;
    lanePcs = '0;
    pos = 0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (cmValid[i]) begin
        lanePcs[pos*PC_WIDTH +: PC_WIDTH] = cmPC[i*PC_WIDTH +: PC_WIDTH];
        pos++;
      end
    end
    laneCount = COUNT_WIDTH'(pos);
  end
endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: rolling committed-PC history that freezes on trigger/hang and drains oldest-first
module commit_trace_buffer #(
  parameter int COMMIT_WIDTH = 2,
  parameter int PC_WIDTH = 32,
  parameter int TRACE_DEPTH = commit_trace_buffer_pkg::TRACE_DEPTH,
  parameter int WATCHDOG_CYCLES = commit_trace_buffer_pkg::WATCHDOG_CYCLES
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [COMMIT_WIDTH-1:0]            cmValid,
  input  logic [COMMIT_WIDTH*PC_WIDTH-1:0]   cmPC,
  input  logic                               arm,
  input  logic                               trigger,
  output logic                               outValid,
  input  logic                               outReady,
  output logic [PC_WIDTH-1:0]                outData,
  output logic                               outLast,
  output logic                               hangDetected,
  output logic [1:0]                         traceState,
  output logic [$clog2(TRACE_DEPTH):0]       entryCount
);
  import commit_trace_buffer_pkg::*;
  localparam int IdxW = $clog2(TRACE_DEPTH);
  localparam int CntW = IdxW + 1;
  localparam int WdW = $clog2(WATCHDOG_CYCLES);
  localparam int LaneW = $clog2(COMMIT_WIDTH + 1);
  localparam logic [CntW:0] FullSum = (CntW + 1)'(TRACE_DEPTH);
  localparam logic [WdW-1:0] WdLast = WdW'(WATCHDOG_CYCLES - 1);

  TraceState state, nextState;
  logic [PC_WIDTH-1:0] traceMem [TRACE_DEPTH];
  logic [IdxW-1:0] wrPtr, rdPtr;
  logic [WdW-1:0] wdCount;
  logic [COMMIT_WIDTH*PC_WIDTH-1:0] lanePcs;
  logic [LaneW-1:0] laneCount;
  logic [CntW:0] sumCount;
  logic capturing, wdExpire, drainFire;

  commit_lane_compactor #(
    .COMMIT_WIDTH(COMMIT_WIDTH),
    .PC_WIDTH(PC_WIDTH),
    .COUNT_WIDTH(LaneW)
  ) compactor (
    .cmValid(cmValid),
    .cmPC(cmPC),
    .lanePcs(lanePcs),
    .laneCount(laneCount)
  );

  assign capturing = state == CAPTURE;
  assign wdExpire = capturing && laneCount == '0 && wdCount == WdLast;
  assign drainFire = outValid && outReady;
  assign sumCount = {1'b0, entryCount} + (CntW + 1)'(laneCount);
  assign traceState = state;

  // state register; reset drops any drain immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nextState;
  end

  // arm wins over everything; FROZEN is a single pointer-setup cycle
  always_comb begin
    nextState = arm ? CAPTURE :
                state == IDLE ? IDLE :
                state == CAPTURE ? ((trigger || wdExpire) ? FROZEN : CAPTURE) :
                state == FROZEN ? (entryCount != '0 ? DRAIN : IDLE) :
                (drainFire && outLast) ? IDLE : DRAIN;
  end

  // drain port is a pure function of state and read pointer, so it holds while stalled
  always_comb begin
    outValid = state == DRAIN;
    outData = outValid ? traceMem[rdPtr] : '0;
    outLast = outValid && entryCount == CntW'(1);
  end

  // history storage is never reset; only entries counted by entryCount are meaningful
  always_ff @(posedge clk) begin
    if (capturing && !arm)
      for (int k = 0; k < COMMIT_WIDTH; k++)
        if (k < int'(laneCount)) traceMem[wrPtr + IdxW'(k)] <= lanePcs[k*PC_WIDTH +: PC_WIDTH];
  end

  // pointers, occupancy, watchdog and sticky hang flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      entryCount <= '0;
      wdCount <= '0;
      hangDetected <= 1'b0;
    end else if (arm) begin
      wrPtr <= '0;
      entryCount <= '0;
      wdCount <= '0;
      hangDetected <= 1'b0;
    end else if (capturing) begin
      wrPtr <= wrPtr + IdxW'(laneCount);
      entryCount <= sumCount > FullSum ? CntW'(TRACE_DEPTH) : sumCount[CntW-1:0];
      wdCount <= (laneCount != '0 || wdExpire) ? '0 : wdCount + 1'b1;
      hangDetected <= hangDetected | wdExpire;
    end else if (state == FROZEN) begin
      rdPtr <= wrPtr - entryCount[IdxW-1:0];
    end else if (drainFire) begin
      rdPtr <= rdPtr + 1'b1;
      entryCount <= entryCount - 1'b1;
    end
  end
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: table vectors, corner sequences and a queue-based random reference
module tb_commit_trace_buffer;
  import commit_trace_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] cmValid = '0;
  logic [63:0] cmPC = '0;
  logic arm = 1'b0, trigger = 1'b0, outReady = 1'b0;
  logic outValid, outLast, hangDetected;
  logic [31:0] outData;
  logic [1:0] traceState;
  TraceCountPath entryCount;

  int vecs = 0;
  int errs = 0;

  TraceState mSt;
  logic [31:0] mHist[$];
  int mIdle;
  logic mHang;

  typedef struct {
    logic a; logic t; logic [1:0] v; logic [31:0] p0; logic [31:0] p1; logic r;
    logic [1:0] st; logic [6:0] cnt; logic ov; logic [31:0] od; logic ol; logic hg;
  } vec_t;
  vec_t tbl[26];

  always #5 clk = ~clk;

  commit_trace_buffer dut (
    .clk(clk), .rst(rst), .cmValid(cmValid), .cmPC(cmPC), .arm(arm), .trigger(trigger),
    .outValid(outValid), .outReady(outReady), .outData(outData), .outLast(outLast),
    .hangDetected(hangDetected), .traceState(traceState), .entryCount(entryCount)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic modelReset();
    mSt = IDLE;
    mHist.delete();
    mIdle = 0;
    mHang = 1'b0;
  endtask

  task automatic modelStep(input logic a, t, input logic [1:0] v, input logic [31:0] p0, p1, input logic r);
    logic expire;
    if (a) begin
      mSt = CAPTURE;
      mHist.delete();
      mIdle = 0;
      mHang = 1'b0;
    end else if (mSt == CAPTURE) begin
      if (v[0]) mHist.push_back(p0);
      if (v[1]) mHist.push_back(p1);
      while (mHist.size() > 64) void'(mHist.pop_front());
      mIdle = (v == 2'b00) ? mIdle + 1 : 0;
      expire = mIdle == 1024;
      if (expire) begin
        mHang = 1'b1;
        mIdle = 0;
      end
      if (t || expire) mSt = FROZEN;
    end else if (mSt == FROZEN) begin
      mSt = (mHist.size() > 0) ? DRAIN : IDLE;
    end else if (mSt == DRAIN && r) begin
      void'(mHist.pop_front());
      if (mHist.size() == 0) mSt = IDLE;
    end
  endtask

  task automatic tick(input logic a, t, input logic [1:0] v, input logic [31:0] p0, p1, input logic r);
    arm = a;
    trigger = t;
    cmValid = v;
    cmPC = {p1, p0};
    outReady = r;
    @(posedge clk);
    modelStep(a, t, v, p0, p1, r);
    #1;
  endtask

  task automatic checkModel(input string tag);
    check({tag, ".state"}, 64'(traceState), 64'(mSt));
    check({tag, ".count"}, 64'(entryCount), 64'(mHist.size()));
    check({tag, ".valid"}, 64'(outValid), 64'(mSt == DRAIN));
    check({tag, ".last"}, 64'(outLast), 64'(mSt == DRAIN && mHist.size() == 1));
    check({tag, ".data"}, 64'(outData), (mSt == DRAIN) ? 64'(mHist[0]) : 64'd0);
    check({tag, ".hang"}, 64'(hangDetected), 64'(mHang));
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 2'b00, 32'h0,    32'h0,    1'b0, 2'd1, 7'd0, 1'b0, 32'h0,    1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 2'b01, 32'h1000, 32'h0,    1'b0, 2'd1, 7'd1, 1'b0, 32'h0,    1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 2'b01, 32'h1004, 32'h0,    1'b0, 2'd1, 7'd2, 1'b0, 32'h0,    1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 2'b01, 32'h1008, 32'h0,    1'b0, 2'd1, 7'd3, 1'b0, 32'h0,    1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 2'b00, 32'h0,    32'h0,    1'b0, 2'd2, 7'd3, 1'b0, 32'h0,    1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 2'b00, 32'h0,    32'h0,    1'b1, 2'd3, 7'd3, 1'b1, 32'h1000, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 2'b00, 32'h0,    32'h0,    1'b1, 2'd3, 7'd2, 1'b1, 32'h1004, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 2'b00, 32'h0,    32'h0,    1'b1, 2'd3, 7'd1, 1'b1, 32'h1008, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 2'b00, 32'h0,    32'h0,    1'b1, 2'd0, 7'd0, 1'b0, 32'h0,    1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 2'b00, 32'h0,    32'h0,    1'b0, 2'd1, 7'd0, 1'b0, 32'h0,    1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 2'b11, 32'h2000, 32'h2004, 1'b0, 2'd1, 7'd2, 1'b0, 32'h0,    1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 2'b10, 32'hdead, 32'h2008, 1'b0, 2'd1, 7'd3, 1'b0, 32'h0,    1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 2'b00, 32'h0,    32'h0,    1'b0, 2'd2, 7'd3, 1'b0, 32'h0,    1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 2'b00, 32'h0,    32'h0,    1'b0, 2'd3, 7'd3, 1'b1, 32'h2000, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 2'b00, 32'h0,    32'h0,    1'b0, 2'd3, 7'd3, 1'b1, 32'h2000, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 2'b00, 32'h0,    32'h0,    1'b1, 2'd3, 7'd2, 1'b1, 32'h2004, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 2'b00, 32'h0,    32'h0,    1'b1, 2'd3, 7'd1, 1'b1, 32'h2008, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 2'b00, 32'h0,    32'h0,    1'b1, 2'd0, 7'd0, 1'b0, 32'h0,    1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 2'b11, 32'h7770, 32'h7774, 1'b0, 2'd1, 7'd0, 1'b0, 32'h0,    1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 2'b01, 32'h5000, 32'h0,    1'b0, 2'd2, 7'd1, 1'b0, 32'h0,    1'b0, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 2'b00, 32'h0,    32'h0,    1'b0, 2'd3, 7'd1, 1'b1, 32'h5000, 1'b1, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 2'b00, 32'h0,    32'h0,    1'b1, 2'd0, 7'd0, 1'b0, 32'h0,    1'b0, 1'b0};
    tbl[22] = '{1'b1, 1'b0, 2'b00, 32'h0,    32'h0,    1'b0, 2'd1, 7'd0, 1'b0, 32'h0,    1'b0, 1'b0};
    tbl[23] = '{1'b0, 1'b1, 2'b00, 32'h0,    32'h0,    1'b0, 2'd2, 7'd0, 1'b0, 32'h0,    1'b0, 1'b0};
    tbl[24] = '{1'b0, 1'b0, 2'b00, 32'h0,    32'h0,    1'b0, 2'd0, 7'd0, 1'b0, 32'h0,    1'b0, 1'b0};
    tbl[25] = '{1'b0, 1'b1, 2'b11, 32'h9000, 32'h9004, 1'b1, 2'd0, 7'd0, 1'b0, 32'h0,    1'b0, 1'b0};

    @(posedge clk);
    #1;
    check("reset.state", 64'(traceState), 64'd0);
    check("reset.count", 64'(entryCount), 64'd0);
    check("reset.valid", 64'(outValid), 64'd0);
    check("reset.data", 64'(outData), 64'd0);
    check("reset.last", 64'(outLast), 64'd0);
    check("reset.hang", 64'(hangDetected), 64'd0);
    rst = 1'b0;
    modelReset();

    for (int i = 0; i < 26; i++) begin
      tick(tbl[i].a, tbl[i].t, tbl[i].v, tbl[i].p0, tbl[i].p1, tbl[i].r);
      check($sformatf("row%0d.state", i), 64'(traceState), 64'(tbl[i].st));
      check($sformatf("row%0d.count", i), 64'(entryCount), 64'(tbl[i].cnt));
      check($sformatf("row%0d.valid", i), 64'(outValid), 64'(tbl[i].ov));
      check($sformatf("row%0d.data", i), 64'(outData), 64'(tbl[i].od));
      check($sformatf("row%0d.last", i), 64'(outLast), 64'(tbl[i].ol));
      check($sformatf("row%0d.hang", i), 64'(hangDetected), 64'(tbl[i].hg));
    end

    tick(1'b1, 1'b0, 2'b00, 0, 0, 1'b0);
    for (int i = 0; i < 70; i++) tick(1'b0, 1'b0, 2'b01, 32'(4 * i), 0, 1'b0);
    tick(1'b0, 1'b1, 2'b00, 0, 0, 1'b0);
    check("wrap.frozen", 64'(traceState), 64'd2);
    check("wrap.count", 64'(entryCount), 64'd64);
    tick(1'b0, 1'b0, 2'b00, 0, 0, 1'b1);
    for (int i = 0; i < 64; i++) begin
      check($sformatf("wrap.data%0d", i), 64'(outData), 64'(32'h18 + 4 * i));
      check($sformatf("wrap.last%0d", i), 64'(outLast), 64'(i == 63));
      tick(1'b0, 1'b0, 2'b00, 0, 0, 1'b1);
    end
    check("wrap.idle", 64'(traceState), 64'd0);

    tick(1'b1, 1'b0, 2'b00, 0, 0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 2'b01, 32'(32'h3000 + 4 * i), 0, 1'b0);
    for (int i = 0; i < 1023; i++) tick(1'b0, 1'b0, 2'b00, 0, 0, 1'b0);
    check("wd1023.hang", 64'(hangDetected), 64'd0);
    check("wd1023.state", 64'(traceState), 64'd1);
    tick(1'b0, 1'b0, 2'b00, 0, 0, 1'b0);
    check("wd1024.hang", 64'(hangDetected), 64'd1);
    check("wd1024.state", 64'(traceState), 64'd2);
    check("wd1024.count", 64'(entryCount), 64'd5);
    tick(1'b0, 1'b0, 2'b00, 0, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("wd.data%0d", i), 64'(outData), 64'(32'h3000 + 4 * i));
      tick(1'b0, 1'b0, 2'b00, 0, 0, 1'b1);
    end
    check("wd.idle", 64'(traceState), 64'd0);
    check("wd.idlehang", 64'(hangDetected), 64'd1);

    tick(1'b1, 1'b0, 2'b00, 0, 0, 1'b0);
    check("both.armclear", 64'(hangDetected), 64'd0);
    for (int i = 0; i < 1023; i++) tick(1'b0, 1'b0, 2'b00, 0, 0, 1'b0);
    tick(1'b0, 1'b1, 2'b00, 0, 0, 1'b0);
    check("both.state", 64'(traceState), 64'd2);
    check("both.hang", 64'(hangDetected), 64'd1);
    tick(1'b0, 1'b0, 2'b00, 0, 0, 1'b0);
    checkModel("both.empty");

    tick(1'b1, 1'b0, 2'b00, 0, 0, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 2'b01, 32'(32'h4000 + 4 * i), 0, 1'b0);
    for (int i = 0; i < 1024; i++) tick(1'b0, 1'b0, 2'b00, 0, 0, 1'b0);
    tick(1'b0, 1'b0, 2'b00, 0, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 2'b00, 0, 0, 1'b0);
      check($sformatf("stall%0d.data", i), 64'(outData), 64'h4000);
      check($sformatf("stall%0d.valid", i), 64'(outValid), 64'd1);
    end
    tick(1'b0, 1'b0, 2'b00, 0, 0, 1'b1);
    check("stall.advance", 64'(outData), 64'h4004);
    check("stall.hang", 64'(hangDetected), 64'd1);
    tick(1'b1, 1'b0, 2'b11, 32'h1111, 32'h2222, 1'b1);
    check("abort.valid", 64'(outValid), 64'd0);
    check("abort.state", 64'(traceState), 64'd1);
    check("abort.count", 64'(entryCount), 64'd0);
    check("abort.hang", 64'(hangDetected), 64'd0);

    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 2'b01, 32'(32'h6000 + 4 * i), 0, 1'b0);
    tick(1'b0, 1'b1, 2'b00, 0, 0, 1'b0);
    tick(1'b0, 1'b0, 2'b00, 0, 0, 1'b0);
    check("arst.pre", 64'(outValid), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    check("arst.state", 64'(traceState), 64'd0);
    check("arst.valid", 64'(outValid), 64'd0);
    check("arst.data", 64'(outData), 64'd0);
    check("arst.last", 64'(outLast), 64'd0);
    check("arst.count", 64'(entryCount), 64'd0);
    modelReset();
    #1;
    rst = 1'b0;
    tick(1'b0, 1'b0, 2'b00, 0, 0, 1'b0);
    checkModel("arst.after");

    for (int i = 0; i < 3000; i++) begin
      logic a, t, r;
      logic [1:0] v;
      a = ($urandom_range(0, 63) == 0) || (mSt == IDLE && $urandom_range(0, 7) == 0);
      t = $urandom_range(0, 59) == 0;
      v = 2'($urandom);
      r = $urandom_range(0, 3) != 0;
      tick(a, t, v, $urandom, $urandom, r);
      checkModel($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Downstream consumer of the debug register block's committed-PC and commit-stage outputs.
- Records a rolling history of committed PCs in a circular buffer and freezes on an external trigger or a commit-stall watchdog timeout.
- After freezing, it streams the history out oldest-first over a valid/ready port for post-mortem hang analysis on FPGA or in simulation.

Parameters:
COMMIT_WIDTH, 2, commit lanes per cycle; matches the core's commit width
PC_WIDTH, 32, width of each recorded PC
TRACE_DEPTH, 64, buffer entries; power of two, >= 2*COMMIT_WIDTH
WATCHDOG_CYCLES, 1024, consecutive commit-free cycles that declare a hang; >= 2

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
cmValid  in  COMMIT_WIDTH  per-lane commit valid from the commit stage
cmPC  in  COMMIT_WIDTH*PC_WIDTH  per-lane committed PC; lane i occupies bits [i*PC_WIDTH +: PC_WIDTH]
arm  in  1  pulse; clears the buffer and starts capture
trigger  in  1  freeze request; honoured only in CAPTURE
outValid  out  1  output entry valid
outReady  in  1  consumer accepts the entry
outData  out  PC_WIDTH  oldest undrained PC
outLast  out  1  outData is the final entry
hangDetected  out  1  sticky watchdog flag
traceState  out  2  current FSM state
entryCount  out  $clog2(TRACE_DEPTH)+1  valid entries currently held

Behaviour:
- Interface: one clock, clk. rst is asynchronous and active-high. All flops use posedge clk or posedge rst.
- Reset values:
  - State is IDLE.
  - wrPtr, rdPtr, entryCount and the watchdog counter are 0.
  - hangDetected, outValid and outLast are 0; outData is 0.
  - Buffer contents are not reset.
- States: IDLE=0, CAPTURE=1, FROZEN=2, DRAIN=3.
- IDLE:
  - Commits are ignored.
  - arm moves to CAPTURE.
- CAPTURE, recording:
  - Valid lanes are compacted in lane order; lane 0 is older.
  - n = popcount(cmValid) entries are written at wrPtr .. wrPtr+n-1, modulo TRACE_DEPTH.
  - wrPtr advances by n.
  - entryCount = min(entryCount+n, TRACE_DEPTH).
  - When the buffer is full, the oldest entries are overwritten.
  - Entries written in a cycle are visible the next cycle.
- CAPTURE, watchdog:
  - The counter increments in every cycle where n == 0 and clears in any cycle where n > 0.
  - If n == 0 while the counter is WATCHDOG_CYCLES-1, then hangDetected goes to 1 and the state goes to FROZEN.
  - With WATCHDOG_CYCLES=1024, the flag rises at the clock edge ending the 1024th consecutive idle cycle.
- CAPTURE, trigger:
  - trigger moves to FROZEN; commits in the same cycle are still recorded.
  - If trigger and the watchdog expire together, the state goes to FROZEN and hangDetected is still set.
- FROZEN lasts exactly one cycle and sets up the read pointer:
  - rdPtr = (wrPtr - entryCount) mod TRACE_DEPTH.
  - Next state is DRAIN if entryCount > 0, else IDLE.
  - outValid is 0.
- DRAIN:
  - outValid = 1, outData = buf[rdPtr], outLast = (entryCount == 1).
  - On outValid && outReady, rdPtr increments with wrap and entryCount decrements.
  - The transfer with outLast=1 moves to IDLE.
  - outData and outLast hold stable while outValid && !outReady.
  - Commits are ignored.
- arm in any state:
  - Forces CAPTURE and clears wrPtr, entryCount, the watchdog counter and hangDetected.
  - Any drain in progress is aborted: outValid drops the next cycle.
  - arm dominates trigger and the watchdog in the same cycle.
  - Commits in the arm cycle are not recorded.
- hangDetected stays set through FROZEN, DRAIN and IDLE, and is cleared only by arm or rst.
- Reset mid-drain: asynchronously returns to IDLE with outValid=0.

Decomposition:
- DebugTypes package gains:
  - the TraceState enum (IDLE, CAPTURE, FROZEN, DRAIN);
  - TRACE_DEPTH and WATCHDOG_CYCLES constants;
  - the TraceIndexPath and TraceCountPath typedefs.
- Sub-module commit_lane_compactor: combinational. It maps cmValid/cmPC to a packed list of written PCs plus count n; this is the only lane-order logic.
- The buffer array, pointers, watchdog and FSM live in commit_trace_buffer.

Test Plan:
- Basic record and drain:
  - Stimulus: arm; commit lane0 PCs 0x1000, 0x1004, 0x1008 on three cycles; trigger.
  - Response: FROZEN, then DRAIN emits 0x1000, 0x1004, 0x1008 with outLast on 0x1008; back to IDLE; hangDetected=0.
- Dual-lane compaction:
  - Stimulus: arm; one cycle with cmValid=2'b11, PCs {0x2004, 0x2000}; next cycle cmValid=2'b10, lane1=0x2008; trigger.
  - Response: drain 0x2000, 0x2004, 0x2008; entryCount=3 at freeze.
- Wrap and overwrite:
  - Stimulus: arm; 70 single commits with PCs 0x0, 0x4, ..., 0x114; trigger.
  - Response: entryCount=64; drain starts at 0x18 and ends at 0x114 with outLast.
- Watchdog:
  - Stimulus: arm; 5 commits; then 1024 idle cycles.
  - Response: hangDetected=1 exactly after the 1024th idle cycle; no hang at 1023 idle cycles; drain yields the 5 PCs.
- Backpressure and abort:
  - Stimulus: during DRAIN hold outReady=0 for 10 cycles, then raise it; mid-drain pulse arm.
  - Response: outData stable while stalled; outValid=0 the cycle after arm; state CAPTURE; entryCount=0; hangDetected=0.
- Empty freeze and async reset:
  - Stimulus: arm then trigger with no commits.
  - Response: FROZEN then IDLE; outValid never asserted.
  - Stimulus: assert rst between clock edges during DRAIN.
  - Response: outputs return to reset values immediately.
